// File: rtl/riscv_seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one op in flight.
// out_valid WIDTH+2 cycles after accept (1 on /0 or overflow); result held until out_ready.
module riscv_seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic             is_rem;
   logic             neg_q;
   logic             neg_r;

   logic             signed_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             b_zero;
   logic             ovf;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;

   assign in_ready = (state == IDLE);

   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & A[WIDTH-1];
      b_neg     = signed_op & B[WIDTH-1];
      abs_a     = a_neg ? -A : A;
      abs_b     = b_neg ? -B : B;
      b_zero    = (B == '0);
      ovf       = signed_op && (A == MIN_NEG) && (B == '1);
      // One extra bit so divisors above 2^(WIDTH-1) compare correctly.
      trial     = {rem, quo[WIDTH-1]};
      diff      = trial - {1'b0, dvsr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         counter   <= '0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         is_rem    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  is_rem <= op[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  if (b_zero) begin
                     result    <= op[1] ? A : '1;
                     div_zero  <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else if (ovf) begin
                     result    <= op[1] ? '0 : MIN_NEG;
                     div_zero  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rem     <= '0;
                     quo     <= abs_a;
                     dvsr    <= abs_b;
                     counter <= CNT_W'(WIDTH);
                     state   <= CALC;
                  end
               end
            end
            CALC: begin
               // quo doubles as the dividend shift register and the quotient.
               if (!diff[WIDTH]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               counter <= counter - CNT_W'(1);
               if (counter == CNT_W'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (is_rem) begin
                  result <= neg_r ? -rem : rem;
               end else begin
                  result <= neg_q ? -quo : quo;
               end
               div_zero  <= 1'b0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_seq_divider.sv
// Directed and random-operand bench for riscv_seq_divider against an arithmetic reference model.
module tb_riscv_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        div_zero;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic rst_edge = 1'b0;

   typedef struct packed {
      logic [31:0] res;
      logic        dz;
      logic        fast;
      logic [31:0] acc;
   } exp_t;

   exp_t q[$];
   bit   front_seen = 0;
   bit   hs_prev    = 0;

   riscv_seq_divider #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .A        (A),
      .B        (B),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= rst;
   end

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endfunction

   // RISC-V division semantics straight from the ISA rules.
   function automatic exp_t model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
      exp_t e;
      int   sa = a;
      int   sb = b;
      e = '0;
      if (b == 32'd0) begin
         e.res  = o[1] ? a : 32'hFFFF_FFFF;
         e.dz   = 1'b1;
         e.fast = 1'b1;
      end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res  = o[1] ? 32'h0 : 32'h8000_0000;
         e.fast = 1'b1;
      end else begin
         case (o)
            2'b00:   e.res = sa / sb;
            2'b01:   e.res = a / b;
            2'b10:   e.res = sa % sb;
            default: e.res = a % b;
         endcase
      end
      return e;
   endfunction

   always @(negedge clk) begin
      #2;
      if (rst_edge) begin
         q.delete();
         front_seen = 0;
         hs_prev    = 0;
         check("rst_out_valid", out_valid, 0);
         check("rst_result", result, 0);
         check("rst_div_zero", div_zero, 0);
         check("rst_in_ready", in_ready, 1);
      end else begin
         if (hs_prev) begin
            check("post_hs_out_valid", out_valid, 0);
            check("post_hs_in_ready", in_ready, 1);
         end
         hs_prev = 0;
         if (q.size() == 0) begin
            check("idle_out_valid", out_valid, 0);
         end else begin
            check("busy_in_ready", in_ready, 0);
            if (out_valid) begin
               if (!front_seen) begin
                  check("latency", cyc + 1 - q[0].acc, q[0].fast ? 32'd1 : 32'd34);
                  front_seen = 1;
               end
               check("result", result, q[0].res);
               check("div_zero", div_zero, q[0].dz);
               if (out_ready) begin
                  hs_prev    = 1;
                  front_seen = 0;
                  void'(q.pop_front());
               end
            end
         end
      end
      if (!rst && in_valid && in_ready) begin
         exp_t e;
         e     = model(op, A, B);
         e.acc = cyc + 1;
         q.push_back(e);
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      in_valid = 1'b1;
      op = o;
      A  = a;
      B  = b;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      op = 2'($urandom);
      A  = $urandom;
      B  = $urandom;
   endtask

   task automatic wait_out(input string nm, output logic [31:0] r, output logic dz);
      int n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_timeout"}, out_valid, 1);
      r  = result;
      dz = div_zero;
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic exp_dz, input string nm);
      logic [31:0] r;
      logic        dz;
      issue(o, a, b);
      wait_out(nm, r, dz);
      check(nm, r, exp_r);
      check({nm, "_dz"}, dz, exp_dz);
      @(negedge clk);
   endtask

   task automatic run_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        dz;
      issue(o, a, b);
      wait_out("rand", r, dz);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] r;
      logic        dz;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 2'b00;
      A         = '0;
      B         = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run(2'b00, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
      run(2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2");
      run(2'b10, 32'h7,         32'hFFFF_FFFE, 32'h1,         1'b0, "rem_7_m2");
      run(2'b11, 32'hFFFF_FFFF, 32'h10,        32'hF,         1'b0, "remu_ff_16");
      run(2'b01, 32'h5,         32'h0,         32'hFFFF_FFFF, 1'b1, "divu_5_0");
      run(2'b11, 32'h5,         32'h0,         32'h5,         1'b1, "remu_5_0");
      run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, "rem_ovf");
      run(2'b00, 32'h8000_0000, 32'h0,         32'hFFFF_FFFF, 1'b1, "div_min_0");
      run(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1,         1'b0, "divu_big_dvsr");
      run(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, "remu_big_dvsr");
      run(2'b00, 32'hFFFF_FF9C, 32'h7,         32'hFFFF_FFF2, 1'b0, "div_m100_7");
      run(2'b10, 32'hFFFF_FF9C, 32'h7,         32'hFFFF_FFFE, 1'b0, "rem_m100_7");
      run(2'b00, 32'h8000_0000, 32'h2,         32'hC000_0000, 1'b0, "div_min_2");
      run(2'b01, 32'h8000_0000, 32'h2,         32'h4000_0000, 1'b0, "divu_min_2");
      run(2'b01, 32'h3,         32'h7,         32'h0,         1'b0, "divu_small");

      // Consumer stall with a competing request parked on the input.
      out_ready = 1'b0;
      issue(2'b01, 32'd100, 32'd7);
      wait_out("hold_divu", r, dz);
      check("hold_divu", r, 32'hE);
      in_valid = 1'b1;
      op = 2'b01;
      A  = 32'd50;
      B  = 32'd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
         check("hold_result", result, 32'hE);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("hs_then_idle", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("hs_then_accept", in_ready, 0);
      wait_out("after_hold", r, dz);
      check("after_hold", r, 32'hA);
      @(negedge clk);

      // Reset in the middle of an iteration must drop the op silently.
      issue(2'b01, 32'd1000, 32'd3);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("abort_out_valid", out_valid, 0);
      end
      run(2'b01, 32'd9, 32'd3, 32'h3, 1'b0, "divu_9_3");

      for (int i = 0; i < 1000; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 15));
            4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            5: b = b | 32'h8000_0000;
            default: ;
         endcase
         run_model(2'($urandom), a, b);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
